// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Accepts a framed byte stream over valid/ready. The frame is LEN_HI, LEN_LO, then N big-endian
// words of DATA_WIDTH/8 bytes each, then one checksum byte. Each assembled word is written into
// the instruction ROM through its write port. The CPU is held in reset while a load is running.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start                   one-cycle pulse that begins a load (ignored while busy)
//   rx_data/valid/ready     incoming byte stream handshake
//   mem_wEn/addr/dataIn     instruction ROM write port
//   busy, cpu_hold          load in progress / CPU held in reset (identical)
//   done, err               sticky completion and failure flags, cleared by start
module imem_loader #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_WIDTH  = 12,
  parameter int unsigned DEPTH          = 4096,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  output logic                     busy,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned BPW  = DATA_WIDTH / 8;
  localparam int unsigned IdxW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IdxW-1:0]          LastIdx  = IdxW'(BPW - 1);
  localparam logic [TmoW-1:0]          TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] BaseAddr = ADDRESS_WIDTH'(BASE_ADDR);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLenHi = 3'd1;
  localparam logic [2:0] StLenLo = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StCheck = 3'd5;
  localparam logic [2:0] StFin   = 3'd6;

  logic [2:0]               state_q, state_d;
  logic [7:0]               sum_q, sum_d;
  logic [15:0]              count_q, count_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [TmoW-1:0]          tmo_q, tmo_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     accept;
  logic [15:0]              len_word;

  assign rx_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
                    (state_q == StData)  || (state_q == StCheck);
  assign accept   = rx_valid && rx_ready;
  // LEN_HI is parked in the top byte of the count register until LEN_LO arrives.
  assign len_word = {count_q[15:8], rx_data};

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    count_d = count_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    word_d  = word_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          sum_d   = 8'h00;
          idx_d   = '0;
          tmo_d   = '0;
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          count_d = {rx_data, 8'h00};
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          if (32'(len_word) > DEPTH) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StFin;
          end else if (len_word == 16'd0) begin
            state_d = StCheck;
          end else begin
            count_d = len_word;
            addr_d  = BaseAddr;
            idx_d   = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_d = (word_q << 8) | DATA_WIDTH'(rx_data);
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StWrite;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StWrite: begin
        addr_d  = addr_q + ADDRESS_WIDTH'(1);
        count_d = count_q - 16'd1;
        state_d = (count_q == 16'd1) ? StCheck : StData;
      end
      StCheck: begin
        if (accept) begin
          err_d   = ((sum_q + rx_data) != 8'h00);
          done_d  = 1'b1;
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Running checksum and inter-byte timeout apply to every byte-accepting state.
    if (accept) begin
      sum_d = sum_q + rx_data;
      tmo_d = '0;
    end else if (rx_ready) begin
      if (tmo_q == TmoLast) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        tmo_d   = '0;
        state_d = StFin;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sum_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q != StIdle) && (state_q != StFin);
  assign cpu_hold   = busy;
  assign done       = done_q;
  assign err        = err_q;
  assign mem_wEn    = (state_q == StWrite);
  assign mem_addr   = addr_q;
  assign mem_dataIn = word_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory. It accepts a framed byte stream from the serial receiver over a valid/ready handshake and assembles the bytes into 32-bit instruction words. Each word is written into the instruction ROM through that ROM's write port (wEn/addr/dataIn). While loading, the block holds the CPU in reset and reports completion or error when the frame ends.

Parameters:
DATA_WIDTH, 32, instruction word width; must be a multiple of 8 (BPW = DATA_WIDTH/8 bytes per word)
ADDRESS_WIDTH, 12, memory address width
DEPTH, 4096, number of memory words; maximum legal word count
BASE_ADDR, 0, address of the first word written
TIMEOUT_CYCLES, 1000000, idle cycles allowed between accepted bytes while busy

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse that begins a load; ignored while busy
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data is valid
rx_ready  output  1  loader accepts the byte this cycle
mem_wEn  output  1  write strobe to the instruction ROM
mem_addr  output  ADDRESS_WIDTH  write address
mem_dataIn  output  DATA_WIDTH  write data
busy  output  1  load in progress
cpu_hold  output  1  holds the CPU in reset; equals busy
done  output  1  sticky; load finished (success or error); cleared by start
err  output  1  sticky; checksum, length or timeout failure; cleared by start

Behaviour:
- Reset is asynchronous and active-high. All outputs go to 0, the FSM goes to IDLE, and the checksum, byte index, word count and timeout counter clear.
- Asserting reset mid-load aborts the load. Memory words already written stay written.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, MSB first), then N*BPW data bytes, then one checksum byte.
- Data words are big-endian: the first byte of each word goes to bits [DATA_WIDTH-1:DATA_WIDTH-8].
- Checksum rule: the 8-bit modulo-256 sum of every frame byte, including LEN and the checksum byte itself, must equal 0x00.
- A byte is accepted on a rising edge where rx_valid && rx_ready.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, FIN.
- IDLE: rx_ready=0. On start: clear done, err and the checksum; set busy; go to LEN_HI.
- LEN_HI / LEN_LO: rx_ready=1. After LEN_LO:
  - N > DEPTH: err=1, go to FIN.
  - N = 0: go to CHECK.
  - Otherwise: load the address with BASE_ADDR and go to DATA.
- DATA: rx_ready=1; bytes shift into the word register. On acceptance of byte BPW of a word, go to WRITE.
- WRITE: lasts exactly one cycle; rx_ready=0, mem_wEn=1, mem_addr = current address, mem_dataIn = assembled word.
  - Then the address increments and the remaining count decrements.
  - If the count reaches 0, go to CHECK; otherwise go back to DATA.
- Write latency: mem_wEn is asserted the cycle after the last byte of a word is accepted.
- Address wraps modulo 2^ADDRESS_WIDTH. The N <= DEPTH check ensures no wrap occurs when BASE_ADDR = 0.
- CHECK: rx_ready=1. On acceptance, err = (sum != 0); go to FIN.
- FIN: lasts one cycle. busy=0, done=1, then go to IDLE. done and err hold until the next start.
- Timeout: the counter resets on every accepted byte and counts while busy in any rx_ready=1 state. On reaching TIMEOUT_CYCLES, set err=1 and go to FIN. Any partial word is discarded.
- mem_wEn is 0 in every state except WRITE; mem_addr and mem_dataIn are don't-care when mem_wEn=0.
- start while busy is ignored. start in the same cycle as the FIN→IDLE transition is ignored.
- rx_valid in IDLE is not accepted; the byte stays pending upstream.
- rx_valid deasserting mid-word stalls the FSM with no state change, apart from the timeout count.

Test Plan:
- Load N=2, words 0x20010005, 0xAC010000, correct checksum (bytes sum 0) → mem_wEn pulses at addr 0 and 1 with those words; done=1, err=0; busy/cpu_hold high from the cycle after start until FIN.
- Same frame with the checksum byte off by one → both words still written; done=1, err=1.
- N=0x1001 (4097) → err=1 and done=1 right after LEN_LO; no mem_wEn.
- N=0 with checksum byte 0x00 → done=1, err=0, no writes.
- N=1 with rx_valid gaps of 0–5 cycles between bytes → word assembled correctly; rx_ready=0 during the single WRITE cycle.
- N=3 with reset asserted after the 6th data byte (TIMEOUT_CYCLES=50 bench override) → all outputs 0 immediately, one word written. Then a frame stalled for 50 cycles → err=1, done=1.
